playfield_renderer: RTL and testbench



---
 rtl/playfield_renderer.sv | 206 ++++++++++++++++++++
 tb/tb_playfield_renderer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_renderer.sv
// playfield_renderer
// Streams one frame of plot commands to the VGA adapter: first every cell of a
// column-major playfield bitmap held in external synchronous RAM, then a
// SPR_W x SPR_H sprite at the position latched on start, clipped to the field.
// Frame length is fixed at FIELD_W*FIELD_H + SPR_W*SPR_H + 2 cycles from the
// start edge to the done pulse.
//
// Optional feature macro: PLAYFIELD_RENDERER_SKIP_BG_EN
//   defined   -> background cells (bitmap 0) are not plotted, so the existing
//                framebuffer contents show through; timing is unchanged.
//   undefined -> background cells are plotted in BG_COLOUR.
module playfield_renderer #(
    parameter int                  FIELD_W     = 120,
    parameter int                  FIELD_H     = 100,
    parameter int                  X_ORG       = 20,
    parameter int                  Y_ORG       = 10,
    parameter int                  SPR_W       = 4,
    parameter int                  SPR_H       = 6,
    parameter int                  COORD_W     = 8,
    parameter int                  ADDR_W      = 14,
    parameter int                  COLOUR_W    = 3,
    parameter logic [COLOUR_W-1:0] WALL_COLOUR = 3'b111,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000,
    parameter logic [COLOUR_W-1:0] SPR_COLOUR  = 3'b100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [COORD_W-1:0]  spr_col,
    input  logic [COORD_W-1:0]  spr_row,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_data,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    // Sized constants so every compare and add below is width-matched.
    localparam int                 N_CELLS   = FIELD_W * FIELD_H;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_CELLS - 1);
    localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(FIELD_H - 1);
    localparam logic [COORD_W-1:0] LAST_DX   = COORD_W'(SPR_W - 1);
    localparam logic [COORD_W-1:0] LAST_DY   = COORD_W'(SPR_H - 1);
    localparam logic [COORD_W-1:0] ONE_C     = COORD_W'(1);
    localparam logic [ADDR_W-1:0]  ONE_A     = ADDR_W'(1);
    localparam logic [COORD_W-1:0] X_ORG_C   = COORD_W'(X_ORG);
    localparam logic [COORD_W-1:0] Y_ORG_C   = COORD_W'(Y_ORG);
    localparam logic [COORD_W:0]   FIELD_W_X = (COORD_W + 1)'(FIELD_W);
    localparam logic [COORD_W:0]   FIELD_H_X = (COORD_W + 1)'(FIELD_H);

    typedef enum logic [2:0] {
        IDLE,
        WALL,
        DRAIN,
        SPRITE,
        DONE
    } state_t;

    state_t             state_reg;
    logic [COORD_W-1:0] spr_col_reg;
    logic [COORD_W-1:0] spr_row_reg;
    // Scan position of the address currently presented to the RAM.
    logic [COORD_W-1:0] col_reg;
    logic [COORD_W-1:0] row_reg;
    // Scan position of the address whose data arrives on rd_data this cycle.
    logic               s1_valid_reg;
    logic [COORD_W-1:0] s1_col_reg;
    logic [COORD_W-1:0] s1_row_reg;
    // Sprite slot counters.
    logic [COORD_W-1:0] dx_reg;
    logic [COORD_W-1:0] dy_reg;

    logic [COORD_W:0]   spr_x_sum;
    logic [COORD_W:0]   spr_y_sum;
    logic               spr_clip;
    logic               wall_plot;

    // Sprite field coordinates kept one bit wider so the clip test sees overflow.
    always_comb begin
        spr_x_sum = {1'b0, spr_col_reg} + {1'b0, dx_reg};
        spr_y_sum = {1'b0, spr_row_reg} + {1'b0, dy_reg};
        spr_clip  = (spr_x_sum >= FIELD_W_X) || (spr_y_sum >= FIELD_H_X);
    end

    // Whether the wall cell arriving from RAM is drawn at all.
    always_comb begin
`ifdef PLAYFIELD_RENDERER_SKIP_BG_EN
        wall_plot = rd_data;
`else
        wall_plot = 1'b1;
`endif
    end

    // Frame sequencer: scan counters, RAM read pipeline and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            spr_col_reg  <= '0;
            spr_row_reg  <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            s1_valid_reg <= 1'b0;
            s1_col_reg   <= '0;
            s1_row_reg   <= '0;
            dx_reg       <= '0;
            dy_reg       <= '0;
            rd_addr      <= '0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            plot         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            if (abort && state_reg != IDLE) begin
                // Cancel silently: no done pulse for an aborted frame.
                state_reg    <= IDLE;
                busy         <= 1'b0;
                s1_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            spr_col_reg  <= spr_col;
                            spr_row_reg  <= spr_row;
                            busy         <= 1'b1;
                            rd_addr      <= '0;
                            col_reg      <= '0;
                            row_reg      <= '0;
                            s1_valid_reg <= 1'b0;
                            state_reg    <= WALL;
                        end
                    end
                    WALL: begin
                        // Data for the previous address is on rd_data now.
                        if (s1_valid_reg) begin
                            x      <= X_ORG_C + s1_col_reg;
                            y      <= Y_ORG_C + s1_row_reg;
                            colour <= rd_data ? WALL_COLOUR : BG_COLOUR;
                            plot   <= wall_plot;
                        end
                        s1_valid_reg <= 1'b1;
                        s1_col_reg   <= col_reg;
                        s1_row_reg   <= row_reg;
                        if (rd_addr == LAST_ADDR) begin
                            state_reg <= DRAIN;
                        end else begin
                            // Incrementing address equals col*FIELD_H+row in this scan order.
                            rd_addr <= rd_addr + ONE_A;
                            if (row_reg == LAST_ROW) begin
                                row_reg <= '0;
                                col_reg <= col_reg + ONE_C;
                            end else begin
                                row_reg <= row_reg + ONE_C;
                            end
                        end
                    end
                    DRAIN: begin
                        // Final wall cell leaves the pipeline.
                        x            <= X_ORG_C + s1_col_reg;
                        y            <= Y_ORG_C + s1_row_reg;
                        colour       <= rd_data ? WALL_COLOUR : BG_COLOUR;
                        plot         <= wall_plot;
                        s1_valid_reg <= 1'b0;
                        dx_reg       <= '0;
                        dy_reg       <= '0;
                        state_reg    <= SPRITE;
                    end
                    SPRITE: begin
                        // Clipped slots still take a cycle so the frame length is fixed.
                        x      <= X_ORG_C + spr_x_sum[COORD_W-1:0];
                        y      <= Y_ORG_C + spr_y_sum[COORD_W-1:0];
                        colour <= SPR_COLOUR;
                        plot   <= ~spr_clip;
                        if (dy_reg == LAST_DY) begin
                            dy_reg <= '0;
                            if (dx_reg == LAST_DX) begin
                                state_reg <= DONE;
                            end else begin
                                dx_reg <= dx_reg + ONE_C;
                            end
                        end else begin
                            dy_reg <= dy_reg + ONE_C;
                        end
                    end
                    DONE: begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_playfield_renderer.sv
// Testbench for playfield_renderer on a 4x3 field with a 2x2 sprite.
// Stimulus pushes the expected plot/done events (with their cycle numbers) into
// queues; a forked monitor pops and compares whenever plot or done is seen.
module tb_playfield_renderer;

    localparam int FW   = 4;
    localparam int FH   = 3;
    localparam int SW   = 2;
    localparam int SH   = 2;
    localparam int XO   = 20;
    localparam int YO   = 10;
    localparam int NP   = FW * FH;
    localparam int NS   = SW * SH;
    localparam int FLEN = NP + NS + 2;
`ifdef PLAYFIELD_RENDERER_SKIP_BG_EN
    localparam bit SKIP_BG = 1'b1;
`else
    localparam bit SKIP_BG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  spr_col;
    logic [7:0]  spr_row;
    logic [13:0] rd_addr;
    logic        rd_data;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    playfield_renderer #(
        .FIELD_W(FW), .FIELD_H(FH), .X_ORG(XO), .Y_ORG(YO),
        .SPR_W(SW), .SPR_H(SH), .COORD_W(8), .ADDR_W(14), .COLOUR_W(3),
        .WALL_COLOUR(3'b111), .BG_COLOUR(3'b000), .SPR_COLOUR(3'b100)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .spr_col(spr_col), .spr_row(spr_row), .rd_addr(rd_addr),
        .rd_data(rd_data), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Bitmap RAM with one cycle of read latency.
    bit mem [NP];
    always @(posedge clk) rd_data <= (int'(rd_addr) < NP) ? mem[int'(rd_addr)] : 1'b0;

    // Edge counter: after posedge number E, cyc == E.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [7:0] px;
        logic [7:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t pq[$];
    int   dq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: wall cell (col,row) sits at slot col*FH+row, sprite
    // slot (dx,dy) at dx*SH+dy after all wall cells; start edge is e.
    task automatic model_frame(input int e, input int sc, input int sr);
        pix_t p;
        for (int c = 0; c < FW; c++) begin
            for (int r = 0; r < FH; r++) begin
                int a = c * FH + r;
                if (mem[a] || !SKIP_BG) begin
                    p.t  = e + 2 + a;
                    p.px = 8'(XO + c);
                    p.py = 8'(YO + r);
                    p.pc = mem[a] ? 3'b111 : 3'b000;
                    pq.push_back(p);
                end
            end
        end
        for (int dx = 0; dx < SW; dx++) begin
            for (int dy = 0; dy < SH; dy++) begin
                if (sc + dx < FW && sr + dy < FH) begin
                    p.t  = e + NP + 2 + dx * SH + dy;
                    p.px = 8'(XO + sc + dx);
                    p.py = 8'(YO + sr + dy);
                    p.pc = 3'b100;
                    pq.push_back(p);
                end
            end
        end
        dq.push_back(e + FLEN);
    endtask

    task automatic drop_from(input int cut);
        while (pq.size() > 0 && pq[$].t >= cut) void'(pq.pop_back());
        while (dq.size() > 0 && dq[$] >= cut) void'(dq.pop_back());
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_y"}, 32'(y), 0);
        chk({tag, "_colour"}, 32'(colour), 0);
        chk({tag, "_plot"}, 32'(plot), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    endtask

    // One complete frame; also pokes start and the sprite inputs mid-frame,
    // both of which must be ignored.
    task automatic run_frame(input int sc, input int sr, input bit with_abort);
        int e;
        @(negedge clk);
        start   = 1'b1;
        abort   = with_abort;
        spr_col = 8'(sc);
        spr_row = 8'(sr);
        e = cyc + 1;
        model_frame(e, sc, sr);
        for (int k = 0; k < NP; k++) begin
            wait_to(e + k);
            chk("rd_addr", 32'(rd_addr), 32'(k));
            if (k == 0) begin
                start   = 1'b0;
                abort   = 1'b0;
                spr_col = 8'($urandom_range(0, 255));
                spr_row = 8'($urandom_range(0, 255));
            end
            if (k == 5) begin
                chk("busy_mid", 32'(busy), 1);
                start = 1'b1;
            end
            if (k == 6) start = 1'b0;
        end
        wait_to(e + FLEN + 1);
        chk("frame_drained", 32'(pq.size() + dq.size()), 0);
        chk("busy_after", 32'(busy), 0);
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < NP; i++) begin
            case (mode)
                0: mem[i] = 1'b0;
                1: mem[i] = 1'b1;
                2: mem[i] = (i == 4);
                default: mem[i] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    initial begin
        int e;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        spr_col = 8'd0;
        spr_row = 8'd0;
        fill_mem(0);

        // Monitor: pops the scoreboard whenever the DUT plots or signals done.
        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    if (plot) begin
                        if (pq.size() == 0) begin
                            chk("unexpected_plot", 1, 0);
                        end else begin
                            pix_t p;
                            p = pq.pop_front();
                            chk("plot_cycle", 32'(cyc), 32'(p.t));
                            chk("plot_x", 32'(x), 32'(p.px));
                            chk("plot_y", 32'(y), 32'(p.py));
                            chk("plot_colour", 32'(colour), 32'(p.pc));
                        end
                    end
                    if (done) begin
                        if (dq.size() == 0) begin
                            chk("unexpected_done", 1, 0);
                        end else begin
                            int t;
                            t = dq.pop_front();
                            chk("done_cycle", 32'(cyc), 32'(t));
                            chk("done_busy", 32'(busy), 0);
                            chk("done_plot", 32'(plot), 0);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // All-ones bitmap, sprite at origin.
        fill_mem(1);
        run_frame(0, 0, 1'b0);
        // Single set cell at address 4 -> (21,11).
        fill_mem(2);
        run_frame(0, 0, 1'b0);
        // Sprite at the field corner: three of four slots clipped.
        fill_mem(3);
        run_frame(3, 2, 1'b0);
        // Random bitmaps and sprite positions, including off-field ones.
        for (int i = 0; i < 6; i++) begin
            fill_mem(3);
            run_frame($urandom_range(0, 6), $urandom_range(0, 5), 1'b0);
        end

        // Abort at start-relative edges 7 and a random one.
        for (int i = 0; i < 2; i++) begin
            int a;
            a = (i == 0) ? 7 : $urandom_range(1, FLEN);
            fill_mem(3);
            @(negedge clk);
            start   = 1'b1;
            spr_col = 8'($urandom_range(0, 4));
            spr_row = 8'($urandom_range(0, 3));
            e = cyc + 1;
            model_frame(e, int'(spr_col), int'(spr_row));
            @(negedge clk);
            start = 1'b0;
            wait_to(e + a - 1);
            abort = 1'b1;
            drop_from(e + a);
            @(negedge clk);
            abort = 1'b0;
            chk("abort_plot", 32'(plot), 0);
            chk("abort_busy", 32'(busy), 0);
            wait_to(e + FLEN + 2);
            chk("abort_drained", 32'(pq.size() + dq.size()), 0);
        end

        // Abort alone in IDLE does nothing.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);
        // Start and abort together in IDLE: the frame runs.
        fill_mem(3);
        run_frame(1, 1, 1'b1);

        // Reset mid-frame with start held high throughout.
        fill_mem(3);
        @(negedge clk);
        start   = 1'b1;
        spr_col = 8'd2;
        spr_row = 8'd1;
        e = cyc + 1;
        model_frame(e, 2, 1);
        wait_to(e + 5);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_reset");
        pq.delete();
        dq.delete();
        @(negedge clk);
        reset = 1'b0;
        e = cyc + 1;
        model_frame(e, 2, 1);
        wait_to(e + 5);
        chk("reset_restart_busy", 32'(busy), 1);
        wait_to(e + FLEN);
        start = 1'b0;
        wait_to(e + FLEN + 3);
        chk("held_start_drained", 32'(pq.size() + dq.size()), 0);
        chk("held_start_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
